// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg : shared load/store-unit types and index-width helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2,
        FIRE      = 2'd3
    } store_fire_state_t;

    localparam int STQ_SIZE_DEFAULT = 32;
    localparam int STQ_IDX_W        = $clog2(STQ_SIZE_DEFAULT);

    // Index width for a queue of the given depth; never narrower than one bit.
    function automatic int idx_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wrapping_counter.sv
// ---------------------------------------------------------------------------
// wrapping_counter : N-bit modulo-2^N counter with increment enable
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wrapping_counter #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [N-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= count + N'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/store_fire_controller.sv
// ---------------------------------------------------------------------------
// store_fire_controller : writes committed STQ head stores to memory and
// pops them once the write is acknowledged.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module store_fire_controller
    import lsu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int STQ_SIZE = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [STQ_SIZE-1:0]                stq_valid,
    input  logic [STQ_SIZE-1:0]                stq_committed,
    input  logic [STQ_SIZE-1:0][XLEN-1:0]      stq_address,
    input  logic [STQ_SIZE-1:0][XLEN-1:0]      stq_data,
    output logic                               mem_req_valid,
    input  logic                               mem_req_ready,
    output logic [XLEN-1:0]                    mem_req_address,
    output logic [XLEN-1:0]                    mem_req_data,
    input  logic                               mem_resp_valid,
    output logic                               store_fired,
    output logic [idx_width(STQ_SIZE)-1:0]     store_fired_index,
    output logic                               stq_pop,
    output logic [idx_width(STQ_SIZE)-1:0]     stq_head,
    output logic                               busy
);

    localparam int IDX_W = idx_width(STQ_SIZE);

    store_fire_state_t state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            mem_req_valid     <= 1'b0;
            mem_req_address   <= '0;
            mem_req_data      <= '0;
            store_fired       <= 1'b0;
            store_fired_index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Request fields are captured here so later STQ changes cannot disturb them.
                    if (stq_valid[stq_head] && stq_committed[stq_head]) begin
                        state           <= REQ;
                        mem_req_valid   <= 1'b1;
                        mem_req_address <= stq_address[stq_head];
                        mem_req_data    <= stq_data[stq_head];
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state         <= WAIT_RESP;
                        mem_req_valid <= 1'b0;
                    end
                end
                WAIT_RESP: begin
                    if (mem_resp_valid) begin
                        state             <= FIRE;
                        store_fired       <= 1'b1;
                        store_fired_index <= stq_head;
                    end
                end
                FIRE: begin
                    state       <= IDLE;
                    store_fired <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    mem_req_valid <= 1'b0;
                    store_fired   <= 1'b0;
                end
            endcase
        end
    end

    assign stq_pop = store_fired;
    assign busy    = (state != IDLE);

    // Head advances on the edge that leaves FIRE.
    wrapping_counter #(
        .N (IDX_W)
    ) u_head_counter (
        .clk   (clk),
        .reset (reset),
        .en    (stq_pop),
        .count (stq_head)
    );

endmodule

`default_nettype wire

// File: doc/store_fire_controller.md
# store_fire_controller

Commit-side controller for the store queue (STQ). Watches the STQ head entry, and once the ROB has marked it committed, writes it to memory over a valid/ready request port and waits for the write acknowledge. It then pulses `store_fired`/`store_fired_index` for one cycle and advances the head pointer. It is the producer of the store-fired event and `stq_head` consumed by `order_failure_detector`, and the pop source for the STQ.

## Interface
- `XLEN`, 32, data/address width
- `STQ_SIZE`, 32, STQ depth; power of two, ≥2
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `stq_valid`  in  STQ_SIZE  entry allocated
- `stq_committed`  in  STQ_SIZE  entry committed by ROB
- `stq_address`  in  STQ_SIZE×XLEN  per-entry store address
- `stq_data`  in  STQ_SIZE×XLEN  per-entry store data
- `mem_req_valid`  out  1  write request valid
- `mem_req_ready`  in  1  memory accepts request
- `mem_req_address`  out  XLEN  write address
- `mem_req_data`  out  XLEN  write data
- `mem_resp_valid`  in  1  write acknowledge, one-cycle pulse
- `store_fired`  out  1  one-cycle pulse: head store written to memory
- `store_fired_index`  out  $clog2(STQ_SIZE)  index of fired store; valid only with `store_fired`
- `stq_pop`  out  1  clear `stq_valid[stq_head]`; equals `store_fired`
- `stq_head`  out  $clog2(STQ_SIZE)  current head index
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, REQ, WAIT_RESP, FIRE.
- IDLE: when `stq_valid[stq_head] && stq_committed[stq_head]`, go to REQ. In the same edge, latch `stq_address[stq_head]` and `stq_data[stq_head]` into request registers.
- REQ: `mem_req_valid`=1. Address and data come from the latched registers and stay stable while valid. On `mem_req_ready`, go to WAIT_RESP. `mem_req_valid` never drops before `mem_req_ready`.
- WAIT_RESP: on `mem_resp_valid`, go to FIRE.
- `mem_resp_valid` in IDLE, REQ or FIRE is ignored; the memory guarantees the acknowledge arrives at least one cycle after the accepting handshake.
- FIRE: `store_fired`=1, `stq_pop`=1, `store_fired_index`=`stq_head`. Next edge: `stq_head` ← `stq_head`+1 mod STQ_SIZE; go to IDLE.
- A new commit check happens only in IDLE, so at most one store is in flight.
- Changes to `stq_committed` or `stq_valid` of the head after leaving IDLE have no effect. Committed stores are never killed, so there is no flush input.

## Timing
- All outputs are decoded from registered state and registered pointers; there is no input-to-output combinational path except none. `mem_req_*` come from registers.
- Reset values: state IDLE, `stq_head` 0, `mem_req_valid` 0, `mem_req_address`/`mem_req_data` 0, `store_fired` 0, `store_fired_index` 0, `stq_pop` 0, `busy` 0.
- Minimum latency, with head committed seen at edge 0 and ready/resp immediate: REQ in cycle 1, WAIT_RESP in cycle 2, FIRE in cycle 3, IDLE with head+1 in cycle 4.
- Peak throughput is one store per 4 cycles.
- Wrap: head STQ_SIZE−1 → 0 after FIRE.
- Empty, or head not committed: remain in IDLE, no outputs toggle.
- Reset asserted mid-operation (any state): immediately return to reset values. An outstanding acknowledge arriving after reset is ignored. The aborted store is not fired and is retried from head 0 by the queue owner.
- `store_fired` is high for exactly one cycle per store; it is never asserted twice for the same entry.

## Structure
- `lsu_pkg`: `store_fire_state_t` enum (IDLE, REQ, WAIT_RESP, FIRE) and the `STQ_IDX_W = $clog2(STQ_SIZE)` convention shared with `order_failure_detector`.
- One natural sub-module: `wrapping_counter #(.N(STQ_IDX_W))` for `stq_head`, with an increment enable equal to `stq_pop`. It is reusable for LDQ head/tail.

## Test plan
- Reset, then entry 0 valid+committed, ready and resp immediate → `mem_req_valid` in cycle 1 with entry-0 address/data; `store_fired`=1 with index 0 in cycle 3; `stq_head`=1 in cycle 4.
- `mem_req_ready` held low 5 cycles → `mem_req_valid` and address/data stable all 5 cycles; `store_fired` exactly 3 cycles after the accepting edge once resp arrives 1 cycle later.
- `stq_head`=STQ_SIZE−1 (31), committed store fired → `store_fired_index`=31, then `stq_head`=0.
- Head valid but not committed for 10 cycles → `busy`=0, no request; commit in cycle 10 → request in cycle 11.
- Spurious `mem_resp_valid` in REQ → stay in REQ; genuine resp in WAIT_RESP → FIRE.
- `reset` pulsed during WAIT_RESP, then late `mem_resp_valid` → no `store_fired`; `stq_head`=0; state IDLE.
